// File: rtl/i2s_pkg.sv
// Shared types and width helpers for the I2S/TDM transmitter.
// No logic; used at elaboration only.
// No flow control.
package i2s_pkg;

    typedef enum logic {
        I2S_STD = 1'b0,
        I2S_LJ  = 1'b1
    } i2s_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tx_state_e;

    // Width of an occupancy counter that must reach the full depth.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Width of a counter running 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous sample FIFO with occupancy level.
// Read data is combinational from the head entry; write visible next cycle.
// Push ignored when full, pop ignored when empty.
module i2s_sample_fifo
    import i2s_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [WIDTH-1:0]          din,
    input  logic                      pop,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic                      empty,
    output logic [lvl_w(DEPTH)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/i2s_tdm_tx.sv
// I2S/TDM serial audio transmitter: FIFO-buffered samples out MSB first, NUM_SLOTS per frame.
// Sample enters FIFO next cycle; first bit driven BCLK_HALF_DIV clks after leaving IDLE.
// s_ready drops when the FIFO is full; an empty FIFO at slot start sends zeros and flags underrun.
module i2s_tdm_tx
    import i2s_pkg::*;
#(
    parameter int BCLK_HALF_DIV = 16,
    parameter int MCLK_HALF_DIV = 4,
    parameter int SAMPLE_WIDTH  = 16,
    parameter int SLOT_WIDTH    = 32,
    parameter int NUM_SLOTS     = 2,
    parameter int MODE          = 0,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [SAMPLE_WIDTH-1:0]         s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic                            clear_underrun,
    output logic                            mclk,
    output logic                            bclk,
    output logic                            ws,
    output logic                            sdata,
    output logic                            frame_start,
    output logic                            underrun_flag,
    output logic [lvl_w(FIFO_DEPTH)-1:0]    fifo_level
);

    localparam int MW = cnt_w(MCLK_HALF_DIV);
    localparam int BW = cnt_w(BCLK_HALF_DIV);
    localparam int PW = cnt_w(SLOT_WIDTH);
    localparam int KW = cnt_w(NUM_SLOTS);
    localparam logic [MW-1:0] M_LAST = MW'(MCLK_HALF_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BCLK_HALF_DIV - 1);
    localparam logic [PW-1:0] P_LAST = PW'(SLOT_WIDTH - 1);
    localparam logic [KW-1:0] K_LAST = KW'(NUM_SLOTS - 1);
    localparam logic [KW-1:0] K_HALF = KW'(NUM_SLOTS / 2);
    localparam i2s_mode_e     MODE_E = (MODE == 1) ? I2S_LJ : I2S_STD;

    tx_state_e                 state;
    logic [MW-1:0]             mclk_cnt;
    logic [BW-1:0]             bclk_cnt;
    logic [PW-1:0]             bit_cnt;
    logic [KW-1:0]             slot_cnt;
    logic [PW-1:0]             nxt_p;
    logic [KW-1:0]             nxt_k;
    logic [SAMPLE_WIDTH-1:0]   shreg;
    logic [SAMPLE_WIDTH-1:0]   fifo_dout;
    logic [SAMPLE_WIDTH-1:0]   sample;
    logic                      started;
    logic                      tick, drive, frame_edge, stop, pop_req;
    logic                      fifo_full, fifo_empty, ws_val;

    i2s_sample_fifo #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s_valid),
        .din   (s_data),
        .pop   (pop_req),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign s_ready = !fifo_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            mclk_cnt <= '0;
            mclk     <= 1'b0;
        end else if (mclk_cnt == M_LAST) begin
            mclk_cnt <= '0;
            mclk     <= ~mclk;
        end else begin
            mclk_cnt <= mclk_cnt + 1'b1;
        end
    end

    // The first tick after leaving IDLE is a data-drive edge even though bclk is already low.
    assign tick       = (state == RUN) && (bclk_cnt == B_LAST);
    assign drive      = tick && (bclk || !started);
    assign frame_edge = drive && (bit_cnt == '0) && (slot_cnt == '0);
    assign stop       = frame_edge && !enable;
    assign pop_req    = drive && (bit_cnt == '0) && !stop;
    assign sample     = fifo_empty ? '0 : fifo_dout;

    always_comb begin
        nxt_p = bit_cnt + 1'b1;
        nxt_k = slot_cnt;
        if (bit_cnt == P_LAST) begin
            nxt_p = '0;
            nxt_k = (slot_cnt == K_LAST) ? '0 : slot_cnt + 1'b1;
        end
        // Standard I2S shows the word select of the bit that follows.
        ws_val = (MODE_E == I2S_LJ) ? (slot_cnt >= K_HALF) : (nxt_k >= K_HALF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bclk_cnt    <= '0;
            bit_cnt     <= '0;
            slot_cnt    <= '0;
            shreg       <= '0;
            started     <= 1'b0;
            bclk        <= 1'b0;
            ws          <= 1'b0;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= RUN;
                        bclk_cnt <= '0;
                        bit_cnt  <= '0;
                        slot_cnt <= '0;
                        started  <= 1'b0;
                    end
                end
                RUN: begin
                    bclk_cnt <= tick ? '0 : bclk_cnt + 1'b1;
                    if (stop) begin
                        state <= IDLE;
                        bclk  <= 1'b0;
                        ws    <= 1'b0;
                        sdata <= 1'b0;
                    end else if (drive) begin
                        bclk        <= 1'b0;
                        started     <= 1'b1;
                        ws          <= ws_val;
                        frame_start <= frame_edge;
                        bit_cnt     <= nxt_p;
                        slot_cnt    <= nxt_k;
                        // Shifted-out zeros supply the padding bits past SAMPLE_WIDTH.
                        if (bit_cnt == '0) begin
                            sdata <= sample[SAMPLE_WIDTH-1];
                            shreg <= sample << 1;
                        end else begin
                            sdata <= shreg[SAMPLE_WIDTH-1];
                            shreg <= shreg << 1;
                        end
                    end else if (tick) begin
                        bclk <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_flag <= 1'b0;
        end else if (pop_req && fifo_empty) begin
            underrun_flag <= 1'b1;
        end else if (clear_underrun) begin
            underrun_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Directed bench for i2s_tdm_tx: a 2-slot I2S instance and an 8-slot left-justified instance.
// Outputs are sampled on the falling clk edge; serial bits are taken where bclk rises.
module tb_i2s_tdm_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        a_en, a_valid, a_ready, a_clr, a_mclk, a_bclk, a_ws, a_sd, a_fs, a_ur;
    logic [15:0] a_data;
    logic [3:0]  a_lvl;
    logic        b_en, b_valid, b_ready, b_clr, b_mclk, b_bclk, b_ws, b_sd, b_fs, b_ur;
    logic [23:0] b_data;
    logic [3:0]  b_lvl;

    int   total = 0;
    int   bad = 0;
    logic cap_d [300];
    logic cap_w [300];
    int   fs_cnt;
    int   period;
    logic rdy_before;
    int   acc, hi;
    logic rdy;
    logic [23:0] s;
    logic [15:0] fill [8] = '{16'hA5F0, 16'h0F0F, 16'hC3C3, 16'h8001,
                              16'h1234, 16'hFFFF, 16'h0001, 16'h7E7E};

    i2s_tdm_tx #(
        .BCLK_HALF_DIV(2), .MCLK_HALF_DIV(4), .SAMPLE_WIDTH(16), .SLOT_WIDTH(16),
        .NUM_SLOTS(2), .MODE(0), .FIFO_DEPTH(8)
    ) u_a (
        .clk(clk), .reset(reset), .enable(a_en), .s_data(a_data), .s_valid(a_valid),
        .s_ready(a_ready), .clear_underrun(a_clr), .mclk(a_mclk), .bclk(a_bclk),
        .ws(a_ws), .sdata(a_sd), .frame_start(a_fs), .underrun_flag(a_ur), .fifo_level(a_lvl)
    );

    i2s_tdm_tx #(
        .BCLK_HALF_DIV(2), .MCLK_HALF_DIV(4), .SAMPLE_WIDTH(24), .SLOT_WIDTH(32),
        .NUM_SLOTS(8), .MODE(1), .FIFO_DEPTH(8)
    ) u_b (
        .clk(clk), .reset(reset), .enable(b_en), .s_data(b_data), .s_valid(b_valid),
        .s_ready(b_ready), .clear_underrun(b_clr), .mclk(b_mclk), .bclk(b_bclk),
        .ws(b_ws), .sdata(b_sd), .frame_start(b_fs), .underrun_flag(b_ur), .fifo_level(b_lvl)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int which, input logic [23:0] d);
        if (which == 0) begin a_valid = 1'b1; a_data = d[15:0]; end
        else            begin b_valid = 1'b1; b_data = d; end
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic wait_fs(input int which);
        int   n;
        logic f;
        n = 0;
        f = 1'b0;
        while (!f && n < 50) begin
            rdy_before = (which == 0) ? a_ready : b_ready;
            @(negedge clk);
            n++;
            f = (which == 0) ? a_fs : b_fs;
        end
        chk("frame_start_seen", 64'(f), 64'd1);
    endtask

    task automatic capture(input int which, input int n, input int drop_at);
        int   got, cyc, last;
        logic prev, b;
        got = 0; cyc = 0; last = 0; fs_cnt = 0; period = 0;
        prev = (which == 0) ? a_bclk : b_bclk;
        while (got < n && cyc < n * 8 + 100) begin
            @(negedge clk);
            cyc++;
            b = (which == 0) ? a_bclk : b_bclk;
            if ((which == 0) ? a_fs : b_fs) fs_cnt++;
            if (b && !prev) begin
                cap_d[got] = (which == 0) ? a_sd : b_sd;
                cap_w[got] = (which == 0) ? a_ws : b_ws;
                if (got > 0) period = cyc - last;
                last = cyc;
                got++;
                if (got == drop_at) begin
                    if (which == 0) a_en = 1'b0;
                    else            b_en = 1'b0;
                end
            end
            prev = b;
        end
        chk("capture_rises", 64'(got), 64'(n));
    endtask

    function automatic logic [31:0] bits(input int start, input int len, input bit use_ws);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < len; i++) r = {r[30:0], use_ws ? cap_w[start + i] : cap_d[start + i]};
        return r;
    endfunction

    task automatic held_idle(input string tag);
        int   rises;
        logic prev;
        rises = 0;
        prev  = a_bclk;
        repeat (20) begin
            @(negedge clk);
            if (a_bclk && !prev) rises++;
            prev = a_bclk;
        end
        chk({tag, "_no_bclk"}, 64'(rises), 64'd0);
        chk({tag, "_pins_low"}, {61'd0, a_bclk, a_ws, a_sd}, 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        a_en = 1'b0; a_valid = 1'b0; a_clr = 1'b0; a_data = '0;
        b_en = 1'b0; b_valid = 1'b0; b_clr = 1'b0; b_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_pins", {57'd0, a_mclk, a_bclk, a_ws, a_sd, a_fs, a_ur, a_ready}, 64'h01);
        chk("rst_level", 64'(a_lvl), 64'd0);
        reset = 1'b0;

        // mclk free-runs with enable low
        hi = 0;
        while (!a_mclk && hi < 20) begin @(negedge clk); hi++; end
        hi = 0;
        do begin @(negedge clk); hi++; end while (a_mclk && hi < 20);
        chk("mclk_half_period", 64'(hi), 64'd4);

        // FIFO fill while disabled
        a_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            a_data = fill[acc % 8];
            rdy = a_ready;
            @(negedge clk);
            if (rdy) acc++;
        end
        a_valid = 1'b0;
        chk("fill_accepted", 64'(acc), 64'd8);
        chk("fill_ready_low", 64'(a_ready), 64'd0);
        chk("fill_level", 64'(a_lvl), 64'd8);

        // first frame, enable dropped mid slot 0
        a_en = 1'b1;
        wait_fs(0);
        chk("ready_before_pop", 64'(rdy_before), 64'd0);
        chk("ready_after_pop", 64'(a_ready), 64'd1);
        chk("level_after_pop", 64'(a_lvl), 64'd7);
        capture(0, 32, 8);
        chk("i2s_data", 64'(bits(0, 32, 0)), 64'hA5F00F0F);
        chk("i2s_ws", 64'(bits(0, 32, 1)), 64'h0001FFFE);
        chk("bclk_period", 64'(period), 64'd4);
        chk("no_extra_fs", 64'(fs_cnt), 64'd0);
        held_idle("stop");
        chk("stop_level", 64'(a_lvl), 64'd6);
        chk("stop_no_underrun", 64'(a_ur), 64'd0);

        // reset in slot 1
        a_en = 1'b1;
        wait_fs(0);
        capture(0, 20, 0);
        chk("pre_reset_bits", 64'(bits(0, 20, 0)), 64'h000C3C38);
        reset = 1'b1;
        a_en  = 1'b0;
        @(negedge clk);
        chk("midreset_pins", {57'd0, a_mclk, a_bclk, a_ws, a_sd, a_fs, a_ur, a_ready}, 64'h01);
        chk("midreset_level", 64'(a_lvl), 64'd0);
        reset = 1'b0;
        push(0, 24'h008421);
        push(0, 24'h007BDE);
        a_en = 1'b1;
        wait_fs(0);
        capture(0, 32, 8);
        chk("restart_data", 64'(bits(0, 32, 0)), 64'h84217BDE);
        chk("restart_ws", 64'(bits(0, 32, 1)), 64'h0001FFFE);
        held_idle("restart");
        chk("restart_level", 64'(a_lvl), 64'd0);

        // underrun with empty FIFO
        a_en = 1'b1;
        wait_fs(0);
        capture(0, 32, 8);
        chk("underrun_data", 64'(bits(0, 32, 0)), 64'h0);
        chk("underrun_set", 64'(a_ur), 64'd1);
        held_idle("underrun");
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        chk("underrun_cleared", 64'(a_ur), 64'd0);
        a_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        a_en  = 1'b0;
        chk("coincide_fs", 64'(a_fs), 64'd1);
        chk("coincide_set_wins", 64'(a_ur), 64'd1);

        // 8-slot left-justified instance
        for (int k = 0; k < 8; k++) push(1, 24'h800001 + 24'(k));
        chk("lj_level", 64'(b_lvl), 64'd8);
        b_en = 1'b1;
        wait_fs(1);
        capture(1, 257, 0);
        b_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            s = 24'h800001 + 24'(k);
            chk($sformatf("lj_slot%0d_data", k), 64'(bits(k * 32, 32, 0)), 64'({s, 8'h00}));
            chk($sformatf("lj_slot%0d_ws", k), 64'(bits(k * 32, 32, 1)),
                (k < 4) ? 64'h0 : 64'hFFFFFFFF);
        end
        chk("lj_fs_per_frame", 64'(fs_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_tdm_tx.md
Name: i2s_tdm_tx

Overview:
Parametrised I2S/TDM serial audio transmitter. It is the successor to the fixed 8-bit stereo transmitter.
- Generates MCLK, BCLK and WS from the system clock using enable strobes. No derived clock domains.
- Accepts samples through a valid/ready stream into an internal FIFO.
- Serialises one sample per slot, MSB first, across NUM_SLOTS slots per frame.
- Sits between the stimulus/sample generator and the external codec/DAC pins.

Parameters:
BCLK_HALF_DIV, 16, clk cycles per BCLK half-period (>=1)
MCLK_HALF_DIV, 4, clk cycles per MCLK half-period (>=1)
SAMPLE_WIDTH, 16, bits per sample (1..32)
SLOT_WIDTH, 32, BCLK periods per slot (>= SAMPLE_WIDTH)
NUM_SLOTS, 2, slots per frame (even, 2..16)
MODE, 0, 0 = I2S (data one BCLK after WS edge), 1 = left-justified (no delay)
FIFO_DEPTH, 8, sample FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
enable  in  1  run request; sampled only at frame boundaries
s_data  in  SAMPLE_WIDTH  sample, slot order 0..NUM_SLOTS-1
s_valid  in  1  s_data valid
s_ready  out  1  FIFO can accept
clear_underrun  in  1  clears underrun_flag
mclk  out  1  master clock
bclk  out  1  bit clock
ws  out  1  word select / frame sync
sdata  out  1  serial data
frame_start  out  1  one-clk pulse when slot-0 MSB is driven
underrun_flag  out  1  sticky underrun indicator
fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (synchronous, all state): mclk=0, bclk=0, ws=0, sdata=0, frame_start=0, underrun_flag=0, fifo_level=0, s_ready=1. FIFO is flushed; counters go to 0; engine goes to IDLE.
- Reset mid-frame aborts the frame immediately. No partial-frame completion.
- mclk toggles every MCLK_HALF_DIV clk cycles, free-running out of reset, independent of enable.
- FIFO push on s_valid && s_ready.
- s_ready = !full, registered state only. A pop in the same cycle does not unblock a push when full.
- Push and pop in the same cycle: level unchanged. On an empty FIFO, the pop is treated as an underrun and the pushed word is retained.
- State machine, IDLE -> RUN:
  - Leave IDLE when enable=1; first BCLK falling edge is BCLK_HALF_DIV clks later.
  - In RUN, bclk toggles every BCLK_HALF_DIV clks.
  - sdata and ws change only on the clk cycle where bclk goes 1->0. The receiver samples on the BCLK rising edge.
- Bit position p (0..SLOT_WIDTH-1) within slot k:
  - sdata = sample[SAMPLE_WIDTH-1-p] for p < SAMPLE_WIDTH, else 0.
  - Bit and slot counters wrap: p to 0 at SLOT_WIDTH-1, k to 0 at NUM_SLOTS-1.
- Sample pop happens on the falling edge that drives p=0 of each slot.
  - If the FIFO is empty: transmit all-zero sample, set underrun_flag.
  - Slot alignment is not resynchronised; the next pop fills the next slot.
- ws is 50% duty: 0 for slots 0..NUM_SLOTS/2-1, 1 for the rest.
  - MODE=0: ws leads by one BCLK; ws on the edge driving position (k,p) equals the half of position (k,p)+1. Frame sync therefore falls during the last bit of the previous frame.
  - MODE=1: ws aligned with the MSB.
- frame_start pulses on the clk cycle of the falling edge driving slot 0, p=0.
- enable=0 is honoured after the last bit of slot NUM_SLOTS-1 completes:
  - bclk is held 0, ws=0, sdata=0, go to IDLE.
  - FIFO is not flushed.
- underrun_flag is cleared by clear_underrun. If clear and a new underrun coincide, the set wins.

Decomposition:
- Package i2s_pkg:
  - i2s_mode_e enum (I2S_STD, I2S_LJ)
  - tx_state_e (IDLE, RUN)
  - clog2-based width helper constants
- Sub-module i2s_sample_fifo: synchronous FIFO with push/pop/full/empty/level.
- Clock dividers and the serialiser stay in the top module.

Test Plan:
All scenarios use SAMPLE_WIDTH=16, SLOT_WIDTH=16, NUM_SLOTS=2, BCLK_HALF_DIV=2 unless noted.
1. MODE=0; push 0xA5F0, 0x0F0F; enable=1 → slot0 sdata 1010010111110000 and slot1 0000111100001111 on successive rising bclk. ws rises one BCLK before the slot-1 MSB. bclk period = 4 clk.
2. MODE=1, SLOT_WIDTH=32, SAMPLE_WIDTH=24, NUM_SLOTS=8; push 8 samples 0x800001..0x800008 → each slot is 24 data bits then 8 zeros. ws is low for slots 0-3 and changes with the slot-0 and slot-4 MSBs. One frame_start per 256 BCLK.
3. Enable with an empty FIFO → sdata stays 0 for the frame and underrun_flag=1. Pulse clear_underrun on the same cycle as a new underrun → flag stays 1.
4. FIFO_DEPTH=8, disabled, hold s_valid → exactly 8 accepted, s_ready=0, fifo_level=8. Enable → s_ready reasserts the cycle after the first pop.
5. Assert reset mid-slot-1 → next cycle all outputs at reset values and fifo_level=0. Restart gives a correct frame from slot 0.
6. Drop enable mid-slot-0 → slot 1 completes fully, then bclk, ws and sdata are held 0. fifo_level retains the unsent samples.
